downscale_wb_engine: RTL and testbench

Streaming 2:1 box-filter downscaler for 8-bit grayscale images, run as a job engine between the N-lane SIMD image memory and its write port. For each job it reads the source image at a runtime base address in N-pixel chunks, averages each 2×2 block, and writes N/2 result pixels per beat to a runtime destination base. Unlike the previous top-level, it writes results back to memory, tolerates per-lane read latency skew and write backpressure, and accepts runtime base addresses.

---
 rtl/downscale_pkg.sv | 30 +++
 rtl/downscale_wb_engine_if.sv | 24 ++
 rtl/ds_lane_gather.sv | 39 +++
 rtl/downscale_wb_engine.sv | 192 +++++++++++++++++++
 tb/tb_downscale_wb_engine.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/downscale_pkg.sv
// Shared types and arithmetic for the 2:1 box-filter downscaler.
// Build option DS_ROUND_EN selects round-half-up averaging instead of truncation.
package downscale_pkg;

    localparam int SUM_W = 10;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_TOP   = 3'd1,
        WAIT_TOP = 3'd2,
        RD_BOT   = 3'd3,
        WAIT_BOT = 3'd4,
        WRITE    = 3'd5,
        FINISH   = 3'd6
    } state_t;

    // Four 8-bit pixels summed in SUM_W bits; even with +2 rounding the max is 1022.
    function automatic logic [7:0] avg4(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c, input logic [7:0] d);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(a) + SUM_W'(b) + SUM_W'(c) + SUM_W'(d);
`ifdef DS_ROUND_EN
        sum = sum + SUM_W'(2);
`else
        sum = sum + SUM_W'(0);
`endif
        return sum[SUM_W-1:2];
    endfunction

endpackage

// File: rtl/downscale_wb_engine_if.sv
// Memory-side bus of the downscaler: N-lane read request/return plus one write beat port.
interface downscale_wb_engine_if #(
    parameter int N      = 4,
    parameter int ADDR_W = 16
);
    logic [N-1:0]          rd_req;
    logic [N*ADDR_W-1:0]   rd_addr;
    logic [N-1:0]          rd_valid;
    logic [N*8-1:0]        rd_data;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [ADDR_W-1:0]     wr_addr;
    logic [(N/2)*8-1:0]    wr_data;

    modport master (
        output rd_req, rd_addr, wr_valid, wr_addr, wr_data,
        input  rd_valid, rd_data, wr_ready
    );

    modport slave (
        input  rd_req, rd_addr, wr_valid, wr_addr, wr_data,
        output rd_valid, rd_data, wr_ready
    );
endinterface

// File: rtl/ds_lane_gather.sv
// Sticky N-lane capture register: each lane latches its first valid after a clear
// and ignores later ones; outputs include same-cycle arrivals.
module ds_lane_gather #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr_i,
    input  logic           en_i,
    input  logic [N-1:0]   valid_i,
    input  logic [N*8-1:0] data_i,
    output logic           all_captured_o,
    output logic [N*8-1:0] data_o
);
    logic [N-1:0]      flag_q, flag_d, take;
    logic [N-1:0][7:0] buf_q, buf_d;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_lane
            assign take[gi]   = en_i & valid_i[gi] & ~flag_q[gi];
            assign flag_d[gi] = clr_i ? 1'b0 : (flag_q[gi] | take[gi]);
            assign buf_d[gi]  = clr_i ? 8'h00 : (take[gi] ? data_i[gi*8 +: 8] : buf_q[gi]);
            assign data_o[gi*8 +: 8] = take[gi] ? data_i[gi*8 +: 8] : buf_q[gi];
        end
    endgenerate

    assign all_captured_o = &(flag_q | take);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_q <= '0;
            buf_q  <= '0;
        end else begin
            flag_q <= flag_d;
            buf_q  <= buf_d;
        end
    end
endmodule

// File: rtl/downscale_wb_engine.sv
// Job engine: reads 2 source rows per chunk, averages 2x2 blocks and writes N/2 pixels per beat.
// Rounding mode selected by DS_ROUND_EN (see downscale_pkg).
module downscale_wb_engine
    import downscale_pkg::*;
#(
    parameter int SRC_W  = 32,
    parameter int SRC_H  = 32,
    parameter int N      = 4,
    parameter int ADDR_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [ADDR_W-1:0]     src_base_i,
    input  logic [ADDR_W-1:0]     dst_base_i,
    downscale_wb_engine_if.master mem,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [15:0]           beats_written_o
);
    localparam int DST_W   = SRC_W / 2;
    localparam int DST_H   = SRC_H / 2;
    localparam int CHUNKS  = SRC_W / N;
    localparam int OUT_N   = N / 2;
    localparam int CHUNK_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int ROW_W   = (DST_H > 1) ? $clog2(DST_H) : 1;

    generate
        if (SRC_W % N != 0) begin : g_bad_src_w
            $error("downscale_wb_engine: SRC_W must be a multiple of N");
        end
        if (SRC_H % 2 != 0) begin : g_bad_src_h
            $error("downscale_wb_engine: SRC_H must be even");
        end
        if ((N % 2 != 0) || (N < 2)) begin : g_bad_n
            $error("downscale_wb_engine: N must be even and at least 2");
        end
    endgenerate

    state_t              state_q, state_d;
    logic [ROW_W-1:0]    orow_q, orow_d;
    logic [CHUNK_W-1:0]  chunk_q, chunk_d;
    logic [ADDR_W-1:0]   src_base_q, src_base_d;
    logic [ADDR_W-1:0]   dst_base_q, dst_base_d;
    logic [15:0]         beats_q, beats_d;
    logic [N-1:0][7:0]   top_q, top_d;
    logic [N-1:0][7:0]   bot_q, bot_d;

    logic                gather_clr, gather_en, all_cap;
    logic [N*8-1:0]      gather_data;
    logic                rd_phase;
    logic [ADDR_W-1:0]   rd_row_addr;
    logic [ADDR_W-1:0]   wr_addr_calc;
    logic                last_chunk, last_row;

    ds_lane_gather #(.N(N)) u_gather (
        .clk           (clk),
        .rst           (rst),
        .clr_i         (gather_clr),
        .en_i          (gather_en),
        .valid_i       (mem.rd_valid),
        .data_i        (mem.rd_data),
        .all_captured_o(all_cap),
        .data_o        (gather_data)
    );

    // Bottom-row reads reuse the top-row address shifted by one source line.
    assign rd_phase    = (state_q == RD_TOP) || (state_q == RD_BOT);
    assign rd_row_addr = src_base_q
                       + ADDR_W'(orow_q) * ADDR_W'(2 * SRC_W)
                       + ADDR_W'(chunk_q) * ADDR_W'(N)
                       + ((state_q == RD_BOT) ? ADDR_W'(SRC_W) : '0);
    assign wr_addr_calc = dst_base_q
                        + ADDR_W'(orow_q) * ADDR_W'(DST_W)
                        + ADDR_W'(chunk_q) * ADDR_W'(OUT_N);

    assign last_chunk = (chunk_q == CHUNK_W'(CHUNKS - 1));
    assign last_row   = (orow_q == ROW_W'(DST_H - 1));

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_rd_lane
            assign mem.rd_req[gi] = rd_phase;
            assign mem.rd_addr[gi*ADDR_W +: ADDR_W] = rd_phase ? (rd_row_addr + ADDR_W'(gi)) : '0;
        end
        for (gi = 0; gi < OUT_N; gi++) begin : g_wr_lane
            assign mem.wr_data[gi*8 +: 8] = (state_q == WRITE)
                ? avg4(top_q[2*gi], top_q[2*gi+1], bot_q[2*gi], bot_q[2*gi+1])
                : 8'h00;
        end
    endgenerate

    assign mem.wr_valid    = (state_q == WRITE);
    assign mem.wr_addr     = (state_q == WRITE) ? wr_addr_calc : '0;
    assign busy_o          = (state_q != IDLE) && (state_q != FINISH);
    assign done_o          = (state_q == FINISH);
    assign beats_written_o = beats_q;

    always_comb begin
        state_d    = state_q;
        orow_d     = orow_q;
        chunk_d    = chunk_q;
        src_base_d = src_base_q;
        dst_base_d = dst_base_q;
        beats_d    = beats_q;
        top_d      = top_q;
        bot_d      = bot_q;
        gather_clr = 1'b0;
        gather_en  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    src_base_d = src_base_i;
                    dst_base_d = dst_base_i;
                    orow_d     = '0;
                    chunk_d    = '0;
                    beats_d    = '0;
                    state_d    = RD_TOP;
                end
            end
            RD_TOP: begin
                gather_clr = 1'b1;
                state_d    = WAIT_TOP;
            end
            WAIT_TOP: begin
                gather_en = 1'b1;
                if (all_cap) begin
                    top_d   = gather_data;
                    state_d = RD_BOT;
                end
            end
            RD_BOT: begin
                gather_clr = 1'b1;
                state_d    = WAIT_BOT;
            end
            WAIT_BOT: begin
                gather_en = 1'b1;
                if (all_cap) begin
                    bot_d   = gather_data;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (mem.wr_ready) begin
                    beats_d = beats_q + 16'd1;
                    if (last_chunk) begin
                        chunk_d = '0;
                        if (last_row) begin
                            orow_d  = '0;
                            state_d = FINISH;
                        end else begin
                            orow_d  = orow_q + ROW_W'(1);
                            state_d = RD_TOP;
                        end
                    end else begin
                        chunk_d = chunk_q + CHUNK_W'(1);
                        state_d = RD_TOP;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            orow_q     <= '0;
            chunk_q    <= '0;
            src_base_q <= '0;
            dst_base_q <= '0;
            beats_q    <= '0;
            top_q      <= '0;
            bot_q      <= '0;
        end else begin
            state_q    <= state_d;
            orow_q     <= orow_d;
            chunk_q    <= chunk_d;
            src_base_q <= src_base_d;
            dst_base_q <= dst_base_d;
            beats_q    <= beats_d;
            top_q      <= top_d;
            bot_q      <= bot_d;
        end
    end
endmodule

// File: tb/tb_downscale_wb_engine.sv
// Directed bench for downscale_wb_engine on an 8x4 image with a modelled skewed-latency memory.
module tb_downscale_wb_engine;
    localparam int SRC_W  = 8;
    localparam int SRC_H  = 4;
    localparam int N      = 4;
    localparam int ADDR_W = 16;
    localparam int DST_W  = SRC_W / 2;
    localparam int DST_H  = SRC_H / 2;
    localparam int CHUNKS = SRC_W / N;
    localparam int OUT_N  = N / 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic [15:0] src_base_i = '0;
    logic [15:0] dst_base_i = '0;
    logic        busy_o, done_o;
    logic [15:0] beats_written_o;

    downscale_wb_engine_if #(.N(N), .ADDR_W(ADDR_W)) bus ();

    downscale_wb_engine #(.SRC_W(SRC_W), .SRC_H(SRC_H), .N(N), .ADDR_W(ADDR_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start_i),
        .src_base_i     (src_base_i),
        .dst_base_i     (dst_base_i),
        .mem            (bus.master),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .beats_written_o(beats_written_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Memory, per-lane return latency, expected write beats
    logic [7:0]  mem [0:65535];
    int          lat [N];
    int          cnt [N];
    logic [15:0] paddr [N];
    bit          dup_en = 1'b0;
    bit          dup_arm = 1'b0;
    logic [15:0] exp_addr [$];
    logic [15:0] exp_data [$];
    int          beat_idx = 0;
    int          stall_beat = -1;
    int          stall_left = 0;

    function automatic logic [7:0] avg_model(input int a, input int b, input int c, input int d);
        int s;
        s = a + b + c + d;
`ifdef DS_ROUND_EN
        return 8'((s + 2) / 4);
`else
        return 8'(s / 4);
`endif
    endfunction

    function automatic int px(input logic [15:0] src, input int r, input int c);
        return int'(mem[16'(int'(src) + r * SRC_W + c)]);
    endfunction

    always @(negedge clk) begin : bus_model
        bus.rd_valid = '0;
        if (dup_arm) begin
            bus.rd_valid[0]  = 1'b1;
            bus.rd_data[7:0] = 8'hEE;
            dup_arm = 1'b0;
        end
        for (int k = 0; k < N; k++) begin
            if (cnt[k] > 0) begin
                cnt[k]--;
                if (cnt[k] == 0) begin
                    bus.rd_valid[k]       = 1'b1;
                    bus.rd_data[k*8 +: 8] = mem[paddr[k]];
                    if (k == 0 && dup_en) dup_arm = 1'b1;
                end
            end
        end
        for (int k = 0; k < N; k++) begin
            if (bus.rd_req[k]) begin
                cnt[k]   = lat[k];
                paddr[k] = bus.rd_addr[k*ADDR_W +: ADDR_W];
            end
        end
        bus.wr_ready = 1'b1;
        if (bus.wr_valid && stall_beat == beat_idx && stall_left > 0) begin
            bus.wr_ready = 1'b0;
            stall_left--;
        end
        if (bus.wr_valid) begin
            if (beat_idx < exp_addr.size()) begin
                check("wr_addr", 64'(bus.wr_addr), 64'(exp_addr[beat_idx]));
                check("wr_data", 64'(bus.wr_data), 64'(exp_data[beat_idx]));
            end else begin
                check("extra_beat", 64'(beat_idx), 64'(exp_addr.size()));
            end
            check("beats_written", 64'(beats_written_o), 64'(beat_idx));
            if (bus.wr_ready) begin
                for (int j = 0; j < OUT_N; j++)
                    mem[bus.wr_addr + 16'(j)] = bus.wr_data[j*8 +: 8];
                beat_idx++;
            end
        end
    end

    task automatic build_expect(input logic [15:0] src, input logic [15:0] dst);
        logic [15:0] d;
        int c;
        exp_addr.delete();
        exp_data.delete();
        beat_idx = 0;
        for (int r = 0; r < DST_H; r++) begin
            for (int ch = 0; ch < CHUNKS; ch++) begin
                for (int j = 0; j < OUT_N; j++) begin
                    c = ch * OUT_N + j;
                    d[j*8 +: 8] = avg_model(px(src, 2*r, 2*c), px(src, 2*r, 2*c+1),
                                            px(src, 2*r+1, 2*c), px(src, 2*r+1, 2*c+1));
                end
                exp_addr.push_back(16'(int'(dst) + r * DST_W + ch * OUT_N));
                exp_data.push_back(d);
            end
        end
    endtask

    task automatic run_job(input logic [15:0] src, input logic [15:0] dst,
                           input int exp_cycles, input int busy_start_at);
        int n;
        int extra;
        n = 0;
        extra = 0;
        build_expect(src, dst);
        @(negedge clk);
        start_i = 1'b1;
        src_base_i = src;
        dst_base_i = dst;
        for (int i = 1; i <= 1000; i++) begin
            @(negedge clk);
            start_i = (i == busy_start_at);
            if (i == busy_start_at) dst_base_i = 16'hDEAD;
            if (i == 1) check("busy_after_start", 64'(busy_o), 64'd1);
            if (done_o) begin
                n = i;
                break;
            end
        end
        start_i = 1'b0;
        check("done_cycle", 64'(n), 64'(exp_cycles));
        check("busy_at_done", 64'(busy_o), 64'd0);
        check("beats_total", 64'(beats_written_o), 64'(DST_H * CHUNKS));
        check("beats_seen", 64'(beat_idx), 64'(DST_H * CHUNKS));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done_o) extra++;
        end
        check("single_done", 64'(extra), 64'd0);
        check("idle_after_job", 64'(busy_o), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_req"},   64'(bus.rd_req),   64'd0);
        check({tag, "_rd_addr"},  64'(bus.rd_addr),  64'd0);
        check({tag, "_wr_valid"}, 64'(bus.wr_valid), 64'd0);
        check({tag, "_wr_addr"},  64'(bus.wr_addr),  64'd0);
        check({tag, "_wr_data"},  64'(bus.wr_data),  64'd0);
        check({tag, "_busy"},     64'(busy_o),       64'd0);
        check({tag, "_done"},     64'(done_o),       64'd0);
        check({tag, "_beats"},    64'(beats_written_o), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        for (int k = 0; k < N; k++) lat[k] = 1;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        $display("reset released");

        // A: flat 100 image, latency 1
        for (int i = 0; i < SRC_W * SRC_H; i++) mem[i] = 8'd100;
        run_job(16'h0000, 16'h0100, 21, 0);
        for (int i = 0; i < 8; i++) check("flat_pixel", 64'(mem[16'h0100 + 16'(i)]), 64'd100);
        check("flat_below", 64'(mem[16'h00FF]), 64'd0);
        check("flat_above", 64'(mem[16'h0108]), 64'd0);
        $display("job A flat image done");

        // B: mixed image with hand-checked blocks
        for (int i = 0; i < SRC_W * SRC_H; i++) mem[16'h0200 + 16'(i)] = 8'($urandom_range(0, 255));
        mem[16'h0200] = 8'd1;   mem[16'h0201] = 8'd2;
        mem[16'h0208] = 8'd2;   mem[16'h0209] = 8'd2;
        mem[16'h0202] = 8'd255; mem[16'h0203] = 8'd255;
        mem[16'h020A] = 8'd255; mem[16'h020B] = 8'd255;
        run_job(16'h0200, 16'h0300, 21, 0);
`ifdef DS_ROUND_EN
        check("block_1222", 64'(mem[16'h0300]), 64'd2);
`else
        check("block_1222", 64'(mem[16'h0300]), 64'd1);
`endif
        check("block_255", 64'(mem[16'h0301]), 64'd255);
        $display("job B mixed image done");

        // C: write backpressure on beat 2 for 3 cycles
        stall_beat = 2;
        stall_left = 3;
        run_job(16'h0200, 16'h0400, 24, 0);
        stall_beat = -1;
        $display("job C backpressure done");

        // D: lane 3 four cycles late, duplicate valid on lane 0
        lat[3] = 5;
        dup_en = 1'b1;
        run_job(16'h0200, 16'h0500, 53, 0);
        dup_en = 1'b0;
        lat[3] = 1;
        $display("job D skewed lanes done");

        // E: start pulsed mid-job with a different destination
        run_job(16'h0200, 16'h0600, 21, 5);
        $display("job E start-while-busy done");

        // F: reset during WAIT_BOT, late lane-3 return afterwards
        lat[3] = 5;
        exp_addr.delete();
        exp_data.delete();
        beat_idx = 0;
        @(negedge clk);
        start_i = 1'b1;
        src_base_i = 16'h0200;
        dst_base_i = 16'h0700;
        @(negedge clk);
        start_i = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("midjob_reset");
        @(negedge clk);
        rst = 1'b0;
        lat[3] = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_reset_busy", 64'(busy_o), 64'd0);
            check("post_reset_rd_req", 64'(bus.rd_req), 64'd0);
        end
        run_job(16'h0200, 16'h0700, 21, 0);
        $display("job F reset recovery done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
